// File: rtl/my_tx_pkg.sv
// Shared types and elaboration-time helpers for the IrDA SIR transmitter.
package my_tx_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StStart,
    StData,
    StStop
  } tx_state_e;

  function automatic int unsigned div_calc(input int unsigned clk_freq,
                                           input int unsigned baud);
    return clk_freq / baud;
  endfunction

  // IrDA pulse is 3/16 of a bit, never shorter than one clock.
  function automatic int unsigned pulse_len(input int unsigned div);
    int unsigned p;
    p = (3 * div) / 16;
    return (p < 1) ? 1 : p;
  endfunction

endpackage

// File: rtl/uart_tx_core.sv
// 8N1 frame engine: FSM, baud counter, shift register and IrDA/raw line encoder.
module uart_tx_core
  import my_tx_pkg::*;
#(
  parameter int unsigned Div      = 10,
  parameter int unsigned PulseLen = 1,
  parameter bit          IrdaEn   = 1'b1
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_start,
  input  logic [7:0] i_din,
  output logic       o_txd,
  output logic       o_busy
);

  localparam int unsigned         CntW     = $clog2(Div);
  localparam logic [CntW-1:0]     LastCnt  = CntW'(Div - 1);
  localparam logic [CntW-1:0]     PulseCnt = CntW'(PulseLen);

  tx_state_e       r_state, w_state_d;
  logic [CntW-1:0] r_cnt, w_cnt_d;
  logic [2:0]      r_idx, w_idx_d;
  logic [7:0]      r_shift, w_shift_d;
  logic            r_txd;
  logic            w_line, w_txd_d, w_bit_end;

  assign w_bit_end = (r_cnt == LastCnt);

  always_comb begin
    w_state_d = r_state;
    w_cnt_d   = r_cnt;
    w_idx_d   = r_idx;
    w_shift_d = r_shift;
    w_line    = 1'b1;
    unique case (r_state)
      StIdle: begin
        w_cnt_d = '0;
        w_idx_d = '0;
        if (i_start) begin
          w_state_d = StStart;
          w_shift_d = i_din;
        end
      end
      StStart: begin
        w_line = 1'b0;
        if (w_bit_end) begin
          w_cnt_d   = '0;
          w_state_d = StData;
        end else begin
          w_cnt_d = r_cnt + CntW'(1);
        end
      end
      StData: begin
        w_line = r_shift[0];
        if (w_bit_end) begin
          w_cnt_d   = '0;
          w_shift_d = r_shift >> 1;
          w_idx_d   = r_idx + 3'd1;
          if (r_idx == 3'd7) w_state_d = StStop;
        end else begin
          w_cnt_d = r_cnt + CntW'(1);
        end
      end
      StStop: begin
        if (w_bit_end) begin
          w_cnt_d   = '0;
          w_state_d = StIdle;
        end else begin
          w_cnt_d = r_cnt + CntW'(1);
        end
      end
      default: w_state_d = StIdle;
    endcase

    // A zero line bit becomes a short high pulse at the head of the bit.
    if (IrdaEn) w_txd_d = ~w_line & (r_cnt < PulseCnt);
    else        w_txd_d = w_line;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= StIdle;
      r_cnt   <= '0;
      r_idx   <= '0;
      r_shift <= '0;
      r_txd   <= ~IrdaEn;
    end else begin
      r_state <= w_state_d;
      r_cnt   <= w_cnt_d;
      r_idx   <= w_idx_d;
      r_shift <= w_shift_d;
      r_txd   <= w_txd_d;
    end
  end

  assign o_txd  = r_txd;
  assign o_busy = (r_state != StIdle);

endmodule

// File: rtl/my_tx.sv
// Board top: KEY[0] synchronizer and edge detector, switch register, frame engine.
module my_tx
  import my_tx_pkg::*;
#(
  parameter int unsigned CLK_FREQ = 50_000_000,
  parameter int unsigned BAUD     = 115_200,
  parameter int unsigned IRDA_EN  = 1
) (
  input  logic       CLOCK_50,
  input  logic [8:0] SW,
  input  logic [0:0] KEY,
  output logic       IRDA_TXD
);

  localparam int unsigned DIV   = div_calc(CLK_FREQ, BAUD);
  localparam int unsigned PULSE = pulse_len(DIV);

  logic       r_key_meta, r_key_sync, r_key_prev;
  logic [7:0] r_sw;
  logic       w_rst, w_rise, w_busy, w_start;

  assign w_rst = SW[8];

  always_ff @(posedge CLOCK_50) begin
    if (w_rst) begin
      r_key_meta <= 1'b0;
      r_key_sync <= 1'b0;
      r_key_prev <= 1'b0;
      r_sw       <= '0;
    end else begin
      r_key_meta <= KEY[0];
      r_key_sync <= r_key_meta;
      r_key_prev <= r_key_sync;
      r_sw       <= SW[7:0];
    end
  end

  assign w_rise  = r_key_sync & ~r_key_prev;
  // Edges seen mid-frame are dropped rather than queued.
  assign w_start = w_rise & ~w_busy;

  uart_tx_core #(
    .Div      (DIV),
    .PulseLen (PULSE),
    .IrdaEn   (IRDA_EN != 0)
  ) u_core (
    .i_clk   (CLOCK_50),
    .i_rst   (w_rst),
    .i_start (w_start),
    .i_din   (r_sw),
    .o_txd   (IRDA_TXD),
    .o_busy  (w_busy)
  );

endmodule

// File: tb/tb_my_tx.sv
// Bench for my_tx: IrDA and raw instances share stimulus; per-cycle expected levels queued.
module tb_my_tx;

  localparam int unsigned DIV = 10;
  localparam int unsigned P   = 1;

  typedef struct packed {
    logic irda;
    logic raw;
  } exp_t;

  logic       clk = 1'b0;
  logic [8:0] sw;
  logic [0:0] key;
  logic       txd_irda, txd_raw;
  exp_t       exp_q[$];
  int         total = 0;
  int         bad   = 0;

  always #10 clk = ~clk;

  my_tx #(.CLK_FREQ(50_000_000), .BAUD(5_000_000), .IRDA_EN(1)) u_dut_irda (
    .CLOCK_50 (clk),
    .SW       (sw),
    .KEY      (key),
    .IRDA_TXD (txd_irda)
  );

  my_tx #(.CLK_FREQ(50_000_000), .BAUD(5_000_000), .IRDA_EN(0)) u_dut_raw (
    .CLOCK_50 (clk),
    .SW       (sw),
    .KEY      (key),
    .IRDA_TXD (txd_raw)
  );

  task automatic push_idle(input int n);
    exp_t e;
    e.irda = 1'b0;
    e.raw  = 1'b1;
    for (int i = 0; i < n; i++) exp_q.push_back(e);
  endtask

  // Queue the first ncyc clocks of a frame carrying d.
  task automatic push_frame(input logic [7:0] d, input int ncyc);
    exp_t e;
    logic line;
    int   j;
    int   pos;
    for (int c = 0; c < ncyc; c++) begin
      j   = c / DIV;
      pos = c % DIV;
      if (j == 0)      line = 1'b0;
      else if (j == 9) line = 1'b1;
      else             line = d[j-1];
      e.irda = ~line & (pos < P);
      e.raw  = line;
      exp_q.push_back(e);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    exp_t e;
    sw  = 9'h100;
    key = 1'b1;
    push_idle(5);
    for (int i = 0; exp_q.size() > 0; i++) begin
      step();
      e = exp_q.pop_front();
      total++;
      if (txd_irda !== e.irda) begin
        bad++;
        $display("FAIL reset_irda cyc=%0d got=%b want=%b", i, txd_irda, e.irda);
      end
      total++;
      if (txd_raw !== e.raw) begin
        bad++;
        $display("FAIL reset_raw cyc=%0d got=%b want=%b", i, txd_raw, e.raw);
      end
      if (i == 4) begin
        sw  = 9'h000;
        key = 1'b0;
        push_idle(30);
      end
    end
  endtask

  task automatic test_frame();
    exp_t e;
    sw  = 9'h0AC;
    key = 1'b1;
    push_idle(3);
    push_frame(8'hAC, 10 * DIV);
    push_idle(10);
    for (int i = 0; exp_q.size() > 0; i++) begin
      step();
      e = exp_q.pop_front();
      total++;
      if (txd_irda !== e.irda) begin
        bad++;
        $display("FAIL frame_irda cyc=%0d got=%b want=%b", i, txd_irda, e.irda);
      end
      total++;
      if (txd_raw !== e.raw) begin
        bad++;
        $display("FAIL frame_raw cyc=%0d got=%b want=%b", i, txd_raw, e.raw);
      end
      if (i == 24) key = 1'b0;
    end
  endtask

  task automatic test_raw();
    exp_t e;
    sw  = 9'h055;
    key = 1'b1;
    push_idle(3);
    push_frame(8'h55, 10 * DIV);
    push_idle(10);
    for (int i = 0; exp_q.size() > 0; i++) begin
      step();
      e = exp_q.pop_front();
      total++;
      if (txd_raw !== e.raw) begin
        bad++;
        $display("FAIL raw_line cyc=%0d got=%b want=%b", i, txd_raw, e.raw);
      end
      total++;
      if (txd_irda !== e.irda) begin
        bad++;
        $display("FAIL raw_irda cyc=%0d got=%b want=%b", i, txd_irda, e.irda);
      end
      if (i == 1) key = 1'b0;
    end
  endtask

  task automatic test_retrigger();
    exp_t e;
    sw  = 9'h03C;
    key = 1'b1;
    push_idle(3);
    push_frame(8'h3C, 10 * DIV);
    push_idle(40);
    for (int i = 0; exp_q.size() > 0; i++) begin
      step();
      e = exp_q.pop_front();
      total++;
      if (txd_irda !== e.irda) begin
        bad++;
        $display("FAIL retrig_irda cyc=%0d got=%b want=%b", i, txd_irda, e.irda);
      end
      total++;
      if (txd_raw !== e.raw) begin
        bad++;
        $display("FAIL retrig_raw cyc=%0d got=%b want=%b", i, txd_raw, e.raw);
      end
      if (i == 2) key = 1'b0;
      if (i == 40) begin
        key = 1'b1;
        sw  = 9'h0FF;
      end
      if (i == 45) key = 1'b0;
    end
  endtask

  task automatic test_mid_reset();
    exp_t e;
    sw  = 9'h0A5;
    key = 1'b1;
    push_idle(3);
    push_frame(8'hA5, 43);
    for (int i = 0; exp_q.size() > 0; i++) begin
      step();
      e = exp_q.pop_front();
      total++;
      if (txd_irda !== e.irda) begin
        bad++;
        $display("FAIL midrst_irda cyc=%0d got=%b want=%b", i, txd_irda, e.irda);
      end
      total++;
      if (txd_raw !== e.raw) begin
        bad++;
        $display("FAIL midrst_raw cyc=%0d got=%b want=%b", i, txd_raw, e.raw);
      end
      if (i == 2) key = 1'b0;
      // Output index 45 is data bit 3 (frame clock 42); reset lands on the next edge.
      if (i == 45) begin
        sw = 9'h1A5;
        push_idle(3);
      end
      if (i == 48) begin
        sw = 9'h0A5;
        push_idle(40);
      end
    end
  endtask

  task automatic test_back_to_back();
    exp_t e;
    sw  = 9'h000;
    key = 1'b1;
    push_idle(3);
    push_frame(8'h00, 10 * DIV);
    push_idle(20);
    push_frame(8'hFF, 10 * DIV);
    push_idle(10);
    for (int i = 0; exp_q.size() > 0; i++) begin
      step();
      e = exp_q.pop_front();
      total++;
      if (txd_irda !== e.irda) begin
        bad++;
        $display("FAIL b2b_irda cyc=%0d got=%b want=%b", i, txd_irda, e.irda);
      end
      total++;
      if (txd_raw !== e.raw) begin
        bad++;
        $display("FAIL b2b_raw cyc=%0d got=%b want=%b", i, txd_raw, e.raw);
      end
      if (i == 5) key = 1'b0;
      if (i == 119) begin
        key = 1'b1;
        sw  = 9'h0FF;
      end
      if (i == 125) key = 1'b0;
    end
  endtask

  initial begin
    sw  = 9'h100;
    key = 1'b1;
    test_reset();
    test_frame();
    test_raw();
    test_retrigger();
    test_mid_reset();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
